// File: rtl/b128to8_pkg.sv
// Shared types and byte-order helper for the 128->8 transmit width converter.
// `B128TO8_LSB_FIRST_EN selects LSB-first byte order; MSB-first when undefined.
package b128to8_pkg;

    localparam int WORD_W         = 128;
    localparam int BYTES_PER_WORD = 16;
    localparam int BYTE_IDX_W     = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SEND = 3'd2,
        ACK  = 3'd3,
        DONE = 3'd4
    } state_e;

    // Only the byte select changes with the build option; timing is identical.
    function automatic logic [7:0] word_byte(input logic [WORD_W-1:0] w,
                                             input logic [BYTE_IDX_W-1:0] idx);
`ifdef B128TO8_LSB_FIRST_EN
        return w[8*int'(idx) +: 8];
`else
        return w[WORD_W-1-8*int'(idx) -: 8];
`endif
    endfunction

endpackage

// File: rtl/bit128to8_if.sv
// DDR read-channel and UART-TX handshake bundle for the 128->8 converter.
interface bit128to8_if;
    import b128to8_pkg::*;

    logic              rd_req;
    logic              rd_data_vld;
    logic [WORD_W-1:0] rd_data;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_busy;
    logic              ovf_err;

    modport master (
        output rd_req, tx_start, tx_data, ovf_err,
        input  rd_data_vld, rd_data, tx_busy
    );

    modport slave (
        input  rd_req, tx_start, tx_data, ovf_err,
        output rd_data_vld, rd_data, tx_busy
    );

endinterface

// File: rtl/sfifo_w128.sv
// Single-clock word FIFO: inferred RAM, 1-cycle registered read, wrap-bit pointers.
module sfifo_w128 #(
    parameter int DEPTH = 128,
    parameter int WIDTH = 128
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     wr_en_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] dout_q;
    logic             wr_ok, rd_ok;

    assign count_o = wr_ptr_q - rd_ptr_q;
    assign empty_o = (count_o == '0);
    assign full_o  = (count_o == (AW+1)'(DEPTH));
    assign rd_ok   = rd_en_i && !empty_o;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign wr_ok   = wr_en_i && (!full_o || rd_ok);
    assign dout_o  = dout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            dout_q   <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                dout_q   <= mem_q[rd_ptr_q[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/bit128to8.sv
// Transmit-side 128->8 converter: requests DDR read bursts, buffers words, serialises to UART TX.
module bit128to8
    import b128to8_pkg::*;
#(
    parameter int BURST_LEN  = 64,
    parameter int FIFO_DEPTH = 128
) (
    input  logic       sclk,
    input  logic       rst_n,
    bit128to8_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(BURST_LEN);

    logic [WORD_W-1:0] fifo_dout;
    logic              fifo_full, fifo_empty;
    logic [AW:0]       fifo_count, free;
    logic              pop;

    logic              rd_req_q, rd_req_d;
    logic              outst_q, outst_d;
    logic [BW-1:0]     beat_cnt_q, beat_cnt_d;
    logic              ovf_q, ovf_d;
    logic              last_beat;

    state_e                state_q, state_d;
    logic [WORD_W-1:0]     word_q, word_d;
    logic [BYTE_IDX_W-1:0] byte_idx_q, byte_idx_d;
    logic                  tx_start_q, tx_start_d;
    logic                  last_byte;

    sfifo_w128 #(.DEPTH(FIFO_DEPTH), .WIDTH(WORD_W)) u_fifo (
        .clk     (sclk),
        .rst_n   (rst_n),
        .din_i   (bus.rd_data),
        .wr_en_i (bus.rd_data_vld),
        .rd_en_i (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Burst request: only one burst in flight, and only when it is guaranteed to fit.
    assign free      = (AW+1)'(FIFO_DEPTH) - fifo_count;
    assign rd_req_d  = !outst_q && (free >= (AW+1)'(BURST_LEN));
    assign last_beat = outst_q && bus.rd_data_vld && (beat_cnt_q == BW'(BURST_LEN-1));

    always_comb begin
        outst_d    = outst_q;
        beat_cnt_d = beat_cnt_q;
        if (rd_req_d) begin
            outst_d    = 1'b1;
            beat_cnt_d = '0;
        end else if (outst_q && bus.rd_data_vld) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
            if (last_beat) outst_d = 1'b0;
        end
        ovf_d = ovf_q | (bus.rd_data_vld && fifo_full && !pop);
    end

    assign last_byte = (byte_idx_q == BYTE_IDX_W'(BYTES_PER_WORD-1));

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (!fifo_empty) state_d = LOAD;
            LOAD: state_d = SEND;
            SEND: state_d = ACK;
            ACK:  if (bus.tx_busy) state_d = DONE;
            DONE: if (!bus.tx_busy) begin
                if (!last_byte)       state_d = SEND;
                else if (!fifo_empty) state_d = LOAD;
                else                  state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop        = 1'b0;
        tx_start_d = 1'b0;
        word_d     = word_q;
        byte_idx_d = byte_idx_q;
        case (state_q)
            IDLE: pop = !fifo_empty;
            LOAD: begin
                word_d     = fifo_dout;
                byte_idx_d = '0;
            end
            SEND: tx_start_d = 1'b1;
            DONE: if (!bus.tx_busy) begin
                if (!last_byte) byte_idx_d = byte_idx_q + 1'b1;
                else            pop = !fifo_empty;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            rd_req_q   <= 1'b0;
            outst_q    <= 1'b0;
            beat_cnt_q <= '0;
            ovf_q      <= 1'b0;
            word_q     <= '0;
            byte_idx_q <= '0;
            tx_start_q <= 1'b0;
        end else begin
            rd_req_q   <= rd_req_d;
            outst_q    <= outst_d;
            beat_cnt_q <= beat_cnt_d;
            ovf_q      <= ovf_d;
            word_q     <= word_d;
            byte_idx_q <= byte_idx_d;
            tx_start_q <= tx_start_d;
        end
    end

    assign bus.rd_req   = rd_req_q;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = word_byte(word_q, byte_idx_q);
    assign bus.ovf_err  = ovf_q;

endmodule

// File: tb/tb_bit128to8.sv
// Bench for bit128to8: DDR burst responder, UART TX model and byte scoreboard.
module tb_bit128to8;
    import b128to8_pkg::*;

    localparam int BURST    = 64;
    localparam int DEPTH    = 128;
    localparam int BUSY_CYC = 10;
    localparam logic [127:0] WORD0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;

    logic sclk  = 1'b0;
    logic rst_n = 1'b1;
    always #5 sclk = ~sclk;

    bit128to8_if bus ();
    bit128to8 #(.BURST_LEN(BURST), .FIFO_DEPTH(DEPTH)) dut (.sclk(sclk), .rst_n(rst_n), .bus(bus));

    int total = 0, bad = 0, cyc = 0;
    bit serve_en = 0, sb_en = 0, hold_busy = 0;
    int man_req = 0, man_sent = 0;
    int burst_left = 0, busy_left = 0, beats_rst = 0;
    bit busy_pend = 0, in_flight = 0;
    int starts = 0, words_started = 0, byte_in_word = 0, req_n = 0, lb_n = 0;
    int req_cyc[4], started_at_req[4], lb_cyc[4];
    logic [7:0] last_tx = '0;
    logic [7:0] first16[16];
    int n_first = 0;
    logic [7:0] exp_q[$];

    function automatic logic [7:0] ref_byte(input logic [127:0] w, input int i);
        logic [127:0] t;
`ifdef B128TO8_LSB_FIRST_EN
        t = w >> (8*i);
`else
        t = w >> (8*(15-i));
`endif
        return t[7:0];
    endfunction

    // Burst responder, UART model and scoreboard; all sampling at negedge.
    task automatic mon_loop();
        logic s_start, s_busy, s_req;
        logic [7:0] s_data, eb;
        logic [127:0] w;
        forever begin
            @(negedge sclk);
            cyc++;
            s_start = bus.tx_start; s_busy = bus.tx_busy; s_req = bus.rd_req; s_data = bus.tx_data;
            if (!rst_n) begin
                burst_left = 0; busy_left = 0; busy_pend = 0; in_flight = 0;
                beats_rst = 0; byte_in_word = 0; req_n = 0; lb_n = 0;
                exp_q.delete();
                man_sent = man_req;
                bus.rd_data_vld = 1'b0; bus.rd_data = '0; bus.tx_busy = hold_busy;
            end else begin
                if (hold_busy) bus.tx_busy = 1'b1;
                else if (busy_left > 0) begin
                    busy_left--;
                    if (busy_left == 0) bus.tx_busy = 1'b0;
                end else if (busy_pend) begin
                    busy_pend = 0; busy_left = BUSY_CYC; bus.tx_busy = 1'b1;
                end else bus.tx_busy = 1'b0;

                if (s_start) begin
                    starts++;
                    if (byte_in_word == 0) words_started++;
                    byte_in_word = (byte_in_word + 1) % 16;
                    last_tx = s_data; busy_pend = 1; in_flight = 1;
                    if (n_first < 16) begin first16[n_first] = s_data; n_first++; end
                    if (sb_en) begin
                        total++;
                        if (exp_q.size() == 0) begin
                            bad++; $display("FAIL tx_byte: got %h, no byte expected", s_data);
                        end else begin
                            eb = exp_q.pop_front();
                            if (s_data !== eb) begin
                                bad++; $display("FAIL tx_byte #%0d: got %h, want %h", starts, s_data, eb);
                            end
                        end
                    end
                end else if (s_busy && in_flight) begin
                    total++;
                    if (s_data !== last_tx) begin
                        bad++; $display("FAIL tx_data_stable: got %h, want %h", s_data, last_tx);
                    end
                end

                if (s_req) begin
                    req_n++;
                    if (req_n < 4) begin req_cyc[req_n] = cyc; started_at_req[req_n] = words_started; end
                    if (serve_en) begin
                        total++;
                        if (burst_left != 0) begin
                            bad++; $display("FAIL single_outstanding: req %0d with %0d beats pending, want 0", req_n, burst_left);
                        end
                        if (req_n < 3) burst_left += BURST;
                    end
                end

                bus.rd_data_vld = 1'b0;
                if (burst_left > 0 || man_sent < man_req) begin
                    if (beats_rst == 0) w = WORD0;
                    else w = {$urandom(), $urandom(), $urandom(), $urandom()};
                    beats_rst++;
                    bus.rd_data_vld = 1'b1; bus.rd_data = w;
                    if (sb_en) for (int i = 0; i < 16; i++) exp_q.push_back(ref_byte(w, i));
                    if (burst_left > 0) begin
                        burst_left--;
                        if (burst_left == 0) begin lb_n++; if (lb_n < 4) lb_cyc[lb_n] = cyc; end
                    end else man_sent++;
                end
            end
        end
    endtask

    task automatic test_reset();
        serve_en = 1; sb_en = 1; hold_busy = 0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge sclk);
        #1;
        total++;
        if ({bus.rd_req, bus.tx_start, bus.ovf_err, bus.tx_data} !== 11'b0) begin
            bad++; $display("FAIL reset_outputs: got %b, want 0", {bus.rd_req, bus.tx_start, bus.ovf_err, bus.tx_data});
        end
        rst_n = 1'b1;
        @(negedge sclk); #1;
        total++;
        if (bus.rd_req !== 1'b1) begin bad++; $display("FAIL first_rd_req: got %b, want 1", bus.rd_req); end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (bus.tx_start !== 1'b0) begin bad++; $display("FAIL no_early_tx_start cyc %0d: got %b, want 0", k, bus.tx_start); end
            @(negedge sclk); #1;
            if (k == 0) begin
                total++;
                if (bus.rd_req !== 1'b0) begin bad++; $display("FAIL rd_req_pulse: got %b, want 0", bus.rd_req); end
            end
        end
    endtask

    task automatic test_stream();
        int t;
        logic [7:0] e;
        t = 0;
        while (req_n < 3 && t < 40000) begin @(negedge sclk); #1; t++; end
        total++;
        if (req_n < 3) begin bad++; $display("FAIL third_rd_req_timeout: got %0d requests, want 3", req_n); end
        t = 0;
        while ((exp_q.size() != 0 || bus.tx_busy) && t < 25000) begin @(negedge sclk); #1; t++; end
        repeat (20) @(negedge sclk);
        #1;
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL drain: got %0d bytes left, want 0", exp_q.size()); end
        for (int i = 0; i < 16; i++) begin
`ifdef B128TO8_LSB_FIRST_EN
            e = 8'(255 - 17*i);
`else
            e = 8'(17*i);
`endif
            total++;
            if (first16[i] !== e) begin bad++; $display("FAIL word0_byte%0d: got %h, want %h", i, first16[i], e); end
        end
        total++;
        if (starts != 128*16) begin bad++; $display("FAIL tx_start_count: got %0d, want %0d", starts, 128*16); end
        total++;
        if (words_started != 128) begin bad++; $display("FAIL words_sent: got %0d, want 128", words_started); end
        total++;
        if (req_cyc[2] - lb_cyc[1] < 1 || req_cyc[2] - lb_cyc[1] > 2) begin
            bad++; $display("FAIL second_req_gap: got %0d cycles, want 1..2", req_cyc[2] - lb_cyc[1]);
        end
        // 3rd request follows the 64th pop; that word's first tx_start is still 3 cycles away.
        total++;
        if (started_at_req[3] != 63) begin bad++; $display("FAIL third_req_timing: got %0d words started, want 63", started_at_req[3]); end
        total++;
        if (req_n != 3) begin bad++; $display("FAIL req_total: got %0d, want 3", req_n); end
    endtask

    task automatic test_overflow();
        int t, beats, exp_cnt;
        hold_busy = 1; serve_en = 0; sb_en = 0;
        @(negedge sclk); #2 rst_n = 1'b0;
        repeat (2) @(negedge sclk);
        #1 rst_n = 1'b1;
        @(negedge sclk); #1;
        // The serialiser pops exactly one word, then stalls in DONE on the held busy.
        beats = 129;
        man_req = man_req + beats;
        t = 0;
        while (man_sent < man_req && t < 400) begin @(negedge sclk); #1; t++; end
        repeat (3) @(negedge sclk);
        #1;
        exp_cnt = (beats - 1 > DEPTH) ? DEPTH : beats - 1;
        total++;
        if (dut.u_fifo.count_o !== 8'(exp_cnt)) begin bad++; $display("FAIL fill_count: got %0d, want %0d", dut.u_fifo.count_o, exp_cnt); end
        total++;
        if (bus.ovf_err !== 1'b0) begin bad++; $display("FAIL ovf_before_full: got %b, want 0", bus.ovf_err); end
        man_req = man_req + 1;
        t = 0;
        while (man_sent < man_req && t < 50) begin @(negedge sclk); #1; t++; end
        repeat (3) @(negedge sclk);
        #1;
        total++;
        if (bus.ovf_err !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b, want 1", bus.ovf_err); end
        total++;
        if (dut.u_fifo.count_o !== 8'(DEPTH)) begin bad++; $display("FAIL count_after_drop: got %0d, want %0d", dut.u_fifo.count_o, DEPTH); end
        repeat (20) @(negedge sclk);
        #1;
        total++;
        if (bus.ovf_err !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b, want 1", bus.ovf_err); end
    endtask

    task automatic test_reset_mid();
        int t, base;
        base = starts;
        hold_busy = 0;
        t = 0;
        while (starts < base + 7 && t < 400) begin @(negedge sclk); #1; t++; end
        repeat (4) @(negedge sclk);
        #1;
        total++;
        if (dut.state_q !== DONE || dut.byte_idx_q !== 4'd7 || bus.ovf_err !== 1'b1) begin
            bad++; $display("FAIL mid_setup: got state %0d idx %0d ovf %b, want DONE 7 1", dut.state_q, dut.byte_idx_q, bus.ovf_err);
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({bus.tx_start, bus.rd_req, bus.ovf_err} !== 3'b0) begin
            bad++; $display("FAIL mid_reset_outputs: got %b, want 000", {bus.tx_start, bus.rd_req, bus.ovf_err});
        end
        repeat (2) @(negedge sclk);
        #1 rst_n = 1'b1;
        @(negedge sclk); #1;
        total++;
        if (bus.rd_req !== 1'b1) begin bad++; $display("FAIL fresh_rd_req: got %b, want 1", bus.rd_req); end
        total++;
        if (dut.state_q !== IDLE || dut.u_fifo.empty_o !== 1'b1 || bus.ovf_err !== 1'b0) begin
            bad++; $display("FAIL post_reset_state: got state %0d empty %b ovf %b, want IDLE 1 0", dut.state_q, dut.u_fifo.empty_o, bus.ovf_err);
        end
    endtask

    initial begin
        fork
            mon_loop();
        join_none
        test_reset();
        test_stream();
        test_overflow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
